// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage F/D/E/M/W pipeline.
// It keeps shadow copies of the hazard-relevant fields of the instructions in
// E, M and W. From these it drives the stall, flush and ALU-operand forwarding
// selects at the Decode/Execute boundary.
// Two saturating counters record load-use stall cycles and taken-branch
// flushes for performance debug.
//
// Ports:
//   clk, rst        clock (rising edge) / asynchronous active-high reset
//   validD          Decode holds a real instruction
//   rs1D, rs2D, rdD register indices of the instruction in Decode
//   regwriteD       instruction in Decode writes the register file
//   resultsrcD      instruction in Decode is a load
//   pcsrcE          taken branch/jump resolved in Execute this cycle
//   clr_cnt         synchronous clear of both counters
//   stallF, stallD  hold PC / hold F/D register
//   flushD, flushE  clear F/D register / clear D/E register (bubble)
//   forwardAE/BE    operand select: 00 RD1E/RD2E, 10 ALU result M, 01 resultW
//   stall_cnt       load-use stall cycles since reset/clear (saturating)
//   flush_cnt       taken-branch flushes since reset/clear (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validD,
    input  logic [NREG_W-1:0] rs1D,
    input  logic [NREG_W-1:0] rs2D,
    input  logic [NREG_W-1:0] rdD,
    input  logic              regwriteD,
    input  logic              resultsrcD,
    input  logic              pcsrcE,
    input  logic              clr_cnt,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [NREG_W-1:0] REG_ZERO = {NREG_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow E stage
    logic              valid_e_r;
    logic [NREG_W-1:0] rs1_e_r;
    logic [NREG_W-1:0] rs2_e_r;
    logic [NREG_W-1:0] rd_e_r;
    logic              regwrite_e_r;
    logic              load_e_r;
    // Shadow M and W stages: only the write-back target matters for forwarding
    logic [NREG_W-1:0] rd_m_r;
    logic              regwrite_m_r;
    logic [NREG_W-1:0] rd_w_r;
    logic              regwrite_w_r;

    logic              lwstall_s;
    logic              stall_s;
    logic              flush_e_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    // Forward select for one operand; M (younger) wins over W, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [NREG_W-1:0] rs,
        input logic [NREG_W-1:0] rd_m,
        input logic              wr_m,
        input logic [NREG_W-1:0] rd_w,
        input logic              wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and forwarding selects
    always_comb begin
        lwstall_s = 1'b0;
        stall_s   = 1'b0;
        flush_e_s = 1'b0;
        fwd_a_s   = 2'b00;
        fwd_b_s   = 2'b00;

        if (validD && valid_e_r && load_e_r && (rd_e_r != REG_ZERO) &&
            ((rd_e_r == rs1D) || (rd_e_r == rs2D))) begin
            lwstall_s = 1'b1;
        end else begin
            lwstall_s = 1'b0;
        end

        // A taken branch squashes the stalled consumer anyway, so fetch must
        // be free to redirect instead of holding.
        stall_s   = lwstall_s & ~pcsrcE;
        flush_e_s = lwstall_s | pcsrcE;

        fwd_a_s = fwd_sel(rs1_e_r, rd_m_r, regwrite_m_r, rd_w_r, regwrite_w_r);
        fwd_b_s = fwd_sel(rs2_e_r, rd_m_r, regwrite_m_r, rd_w_r, regwrite_w_r);
    end

    assign stallF    = stall_s;
    assign stallD    = stall_s;
    assign flushD    = pcsrcE;
    assign flushE    = flush_e_s;
    assign forwardAE = fwd_a_s;
    assign forwardBE = fwd_b_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // Shadow E stage: capture Decode fields, or a bubble when E is flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_e_r    <= 1'b0;
            rs1_e_r      <= REG_ZERO;
            rs2_e_r      <= REG_ZERO;
            rd_e_r       <= REG_ZERO;
            regwrite_e_r <= 1'b0;
            load_e_r     <= 1'b0;
        end else if (flush_e_s) begin
            valid_e_r    <= 1'b0;
            rs1_e_r      <= REG_ZERO;
            rs2_e_r      <= REG_ZERO;
            rd_e_r       <= REG_ZERO;
            regwrite_e_r <= 1'b0;
            load_e_r     <= 1'b0;
        end else begin
            valid_e_r    <= validD;
            rs1_e_r      <= rs1D;
            rs2_e_r      <= rs2D;
            rd_e_r       <= rdD;
            regwrite_e_r <= regwriteD & validD;
            load_e_r     <= resultsrcD & validD;
        end
    end

    // Shadow M and W stages: advance every cycle, they never stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_m_r       <= REG_ZERO;
            regwrite_m_r <= 1'b0;
            rd_w_r       <= REG_ZERO;
            regwrite_w_r <= 1'b0;
        end else begin
            rd_m_r       <= rd_e_r;
            regwrite_m_r <= regwrite_e_r;
            rd_w_r       <= rd_m_r;
            regwrite_w_r <= regwrite_m_r;
        end
    end

    // Load-use stall counter: clear wins, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (clr_cnt) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Taken-branch flush counter: clear wins, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_r <= CNT_ZERO;
        end else if (clr_cnt) begin
            flush_cnt_r <= CNT_ZERO;
        end else if (pcsrcE && (flush_cnt_r != CNT_MAX)) begin
            flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

endmodule
